vga_timing_multi: RTL and testbench
===================================

VGA_TIMING_MULTI -- requirements
Module: vga_timing_multi

Interface
REQ-001 The block SHALL have parameter CNT_W, default 11, width of the hcount/vcount outputs.
REQ-002 The block SHALL have parameter RST_MODE, default 0, the mode loaded at reset (0 = 800x600@60, 1 = 640x480@60).
REQ-003 Port clk  input  1  system clock, all state on its rising edge.
REQ-004 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port en  input  1  pixel enable; counters advance only on cycles with en=1.
REQ-006 Port mode_sel  input  1  requested mode, same encoding as RST_MODE.
REQ-007 Port hcount  output  CNT_W  current pixel column.
REQ-008 Port vcount  output  CNT_W  current line.
REQ-009 Port hsync  output  1  horizontal sync, at the active mode's polarity.
REQ-010 Port vsync  output  1  vertical sync, at the active mode's polarity.
REQ-011 Port hblnk  output  1  horizontal blanking.
REQ-012 Port vblnk  output  1  vertical blanking.
REQ-013 Port frame_start  output  1  one-cycle pulse at the first pixel of a frame.
REQ-014 Port mode_act  output  1  mode currently in force.

Function
REQ-015 Mode 0 SHALL use these values: H total 1056, H blank start 800, hsync 840..967, V total 628, V blank start 600, vsync 601..604, sync polarity positive.
REQ-016 Mode 1 SHALL use these values: H total 800, H blank start 640, hsync 656..751, V total 525, V blank start 480, vsync 490..491, sync polarity negative.
REQ-017 All outputs SHALL be registered; hsync, vsync, hblnk, vblnk and frame_start SHALL correspond to the hcount/vcount values shown in the same cycle (zero relative latency).
REQ-018 On a cycle with en=1, hcount SHALL increment by 1; at H total-1 it SHALL wrap to 0 and vcount SHALL increment by 1.
REQ-019 On a cycle with en=1 at hcount = H total-1 and vcount = V total-1, both counters SHALL wrap to 0.
REQ-020 On cycles with en=0, every output SHALL hold its value, and frame_start SHALL be 0.
REQ-021 hblnk SHALL be 1 exactly when hcount >= H blank start of mode_act.
REQ-022 vblnk SHALL be 1 exactly when vcount >= V blank start of mode_act.
REQ-023 hsync SHALL be at its active level exactly when hcount is inside the hsync window, and at its inactive level otherwise.
REQ-024 vsync SHALL be at its active level exactly when vcount is inside the vsync window, and at its inactive level otherwise.
REQ-025 Active level SHALL be 1 for positive polarity and 0 for negative polarity.
REQ-026 frame_start SHALL be 1 for exactly one cycle, the cycle in which the outputs first show (0,0) after a frame wrap.
REQ-027 mode_sel SHALL be sampled only on the frame-wrap cycle of REQ-019; if it differs from mode_act, mode_act SHALL take the new value together with the counter wrap to (0,0).
REQ-028 From the frame-wrap cycle on, all decodes SHALL use the new mode's values.
REQ-029 A change of mode_sel at any other time SHALL have no effect, including toggling away and back before the wrap.
REQ-030 The counters SHALL never show a value >= the active mode's total.
REQ-031 A mode change SHALL not produce a partial line, a partial frame or a glitch on sync.

Reset
REQ-032 While rst_n=0, the outputs SHALL be: hcount=0, vcount=0, hblnk=0, vblnk=0, frame_start=0, mode_act=RST_MODE.
REQ-033 While rst_n=0, hsync and vsync SHALL be at the inactive level of RST_MODE (mode 0: 0; mode 1: 1).
REQ-034 Reset asserted mid-frame SHALL force the REQ-032/033 values immediately, regardless of clk.
REQ-035 After release, counting SHALL resume from (0,0) on the first edge with en=1.
REQ-036 frame_start SHALL not pulse at reset release; its first pulse SHALL be at the first frame wrap.

Verification
REQ-037 Mode 0, en=1 continuous -> hsync high for hcount 840..967 (128 cycles) per line; vsync high for lines 601..604; frame_start period 1056*628 = 663168 cycles.
REQ-038 Mode 1 at reset (RST_MODE=1) -> hsync=1 in reset, low for hcount 656..751; vsync low for lines 490..491; frame_start period 800*525 = 420000 cycles.
REQ-039 Mode 0, mode_sel driven 0->1 at line 300 -> mode_act stays 0 until (1055,627), then shows (0,0) with mode_act=1 and frame_start=1; next wrap at (799,524).
REQ-040 en toggling 1,0,1,0 -> counters advance every second cycle; no output change on en=0 cycles; frame_start width 1 cycle.
REQ-041 rst_n pulsed low at (500,300) asynchronously between edges -> outputs reach reset values before the next edge; restart at (0,0); no frame_start until the next wrap.
REQ-042 mode_sel toggled 0->1->0 within one frame in mode 0 -> no mode change at the wrap; blanking boundaries 800/600 hold throughout.

Source files
------------

// File: rtl/vga_timing_multi.sv
// VGA raster timing generator for 800x600@60 and 640x480@60.
// A mode change requested on mode_sel takes effect only at the frame wrap.
module vga_timing_multi #(
    parameter int unsigned CNT_W    = 11,
    parameter logic        RST_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode_sel,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             hblnk,
    output logic             vblnk,
    output logic             frame_start,
    output logic             mode_act
);

    // Mode 0: 800x600@60, positive syncs
    localparam int unsigned M0_H_TOT  = 1056;
    localparam int unsigned M0_H_BLK  = 800;
    localparam int unsigned M0_HS_BEG = 840;
    localparam int unsigned M0_HS_END = 967;
    localparam int unsigned M0_V_TOT  = 628;
    localparam int unsigned M0_V_BLK  = 600;
    localparam int unsigned M0_VS_BEG = 601;
    localparam int unsigned M0_VS_END = 604;

    // Mode 1: 640x480@60, negative syncs
    localparam int unsigned M1_H_TOT  = 800;
    localparam int unsigned M1_H_BLK  = 640;
    localparam int unsigned M1_HS_BEG = 656;
    localparam int unsigned M1_HS_END = 751;
    localparam int unsigned M1_V_TOT  = 525;
    localparam int unsigned M1_V_BLK  = 480;
    localparam int unsigned M1_VS_BEG = 490;
    localparam int unsigned M1_VS_END = 491;

    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic             mode_q, mode_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             hblnk_q, hblnk_d;
    logic             vblnk_q, vblnk_d;
    logic             frame_start_q, frame_start_d;

    logic [CNT_W-1:0] h_last, v_last;
    logic             line_end, frame_end;

    // Counter advance; the requested mode is sampled only on the frame wrap
    always_comb begin : counter_next
        h_last        = mode_q ? CNT_W'(M1_H_TOT - 1) : CNT_W'(M0_H_TOT - 1);
        v_last        = mode_q ? CNT_W'(M1_V_TOT - 1) : CNT_W'(M0_V_TOT - 1);
        line_end      = (hcount_q >= h_last);
        frame_end     = line_end && (vcount_q >= v_last);
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        mode_d        = mode_q;
        frame_start_d = en && frame_end;
        if (en) begin
            if (line_end) begin
                hcount_d = '0;
                if (frame_end) begin
                    vcount_d = '0;
                    mode_d   = mode_sel;
                end else begin
                    vcount_d = vcount_q + 1'b1;
                end
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end
    end

    logic [CNT_W-1:0] h_blk, hs_beg, hs_end, v_blk, vs_beg, vs_end;
    logic             sync_pos;

    // Decode from the next counter values and next mode so registered outputs line up
    always_comb begin : decode
        h_blk    = mode_d ? CNT_W'(M1_H_BLK)  : CNT_W'(M0_H_BLK);
        hs_beg   = mode_d ? CNT_W'(M1_HS_BEG) : CNT_W'(M0_HS_BEG);
        hs_end   = mode_d ? CNT_W'(M1_HS_END) : CNT_W'(M0_HS_END);
        v_blk    = mode_d ? CNT_W'(M1_V_BLK)  : CNT_W'(M0_V_BLK);
        vs_beg   = mode_d ? CNT_W'(M1_VS_BEG) : CNT_W'(M0_VS_BEG);
        vs_end   = mode_d ? CNT_W'(M1_VS_END) : CNT_W'(M0_VS_END);
        sync_pos = ~mode_d;
        hblnk_d  = (hcount_d >= h_blk);
        vblnk_d  = (vcount_d >= v_blk);
        hsync_d  = ((hcount_d >= hs_beg) && (hcount_d <= hs_end)) ~^ sync_pos;
        vsync_d  = ((vcount_d >= vs_beg) && (vcount_d <= vs_end)) ~^ sync_pos;
    end

    // Inactive sync level equals the mode code (mode 0 idles low, mode 1 idles high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            mode_q        <= RST_MODE;
            hsync_q       <= RST_MODE;
            vsync_q       <= RST_MODE;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            mode_q        <= mode_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hblnk       = hblnk_q;
    assign vblnk       = vblnk_q;
    assign frame_start = frame_start_q;
    assign mode_act    = mode_q;

endmodule

// File: tb/tb_vga_timing_multi.sv
// Random-stimulus bench for vga_timing_multi: two instances (reset mode 0 and 1)
// compared every cycle against a raster model; long stretches are skipped by preloading.
module tb_vga_timing_multi;

    localparam int CNT_W = 11;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             mode_sel;
    logic [CNT_W-1:0] hc [2];
    logic [CNT_W-1:0] vc [2];
    logic             hs [2];
    logic             vs [2];
    logic             hb [2];
    logic             vb [2];
    logic             fs [2];
    logic             ma [2];

    logic [CNT_W-1:0] jh0, jv0, jh1, jv1;

    int checks;
    int errors;
    int mh [2];
    int mv [2];
    int mm [2];
    int mfs [2];

    int seq_kind [12] = '{0, 1, 2, 3, 4, 4, 4, 0, 3, 4, 4, 4};
    int seq_sel  [12] = '{2, 2, 2, 2, 1, 0, 2, 2, 2, 1, 1, 2};

    vga_timing_multi #(.CNT_W(CNT_W), .RST_MODE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode_sel(mode_sel),
        .hcount(hc[0]), .vcount(vc[0]), .hsync(hs[0]), .vsync(vs[0]),
        .hblnk(hb[0]), .vblnk(vb[0]), .frame_start(fs[0]), .mode_act(ma[0])
    );

    vga_timing_multi #(.CNT_W(CNT_W), .RST_MODE(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode_sel(mode_sel),
        .hcount(hc[1]), .vcount(vc[1]), .hsync(hs[1]), .vsync(vs[1]),
        .hblnk(hb[1]), .vblnk(vb[1]), .frame_start(fs[1]), .mode_act(ma[1])
    );

    always #5 clk = ~clk;

    function automatic int htot(int m); return (m != 0) ? 800 : 1056; endfunction
    function automatic int hbs (int m); return (m != 0) ? 640 : 800;  endfunction
    function automatic int hs0 (int m); return (m != 0) ? 656 : 840;  endfunction
    function automatic int hs1 (int m); return (m != 0) ? 751 : 967;  endfunction
    function automatic int vtot(int m); return (m != 0) ? 525 : 628;  endfunction
    function automatic int vbs (int m); return (m != 0) ? 480 : 600;  endfunction
    function automatic int vs0 (int m); return (m != 0) ? 490 : 601;  endfunction
    function automatic int vs1 (int m); return (m != 0) ? 491 : 604;  endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mh[i]  = 0;
            mv[i]  = 0;
            mm[i]  = i;
            mfs[i] = 0;
        end
    endtask

    // One enabled pixel moves the raster; the frame wrap also adopts the requested mode
    task automatic model_step(input logic en_v, input logic sel_v);
        for (int i = 0; i < 2; i++) begin
            mfs[i] = 0;
            if (en_v) begin
                if (mh[i] == htot(mm[i]) - 1) begin
                    mh[i] = 0;
                    if (mv[i] == vtot(mm[i]) - 1) begin
                        mv[i]  = 0;
                        mm[i]  = int'(sel_v);
                        mfs[i] = 1;
                    end else begin
                        mv[i]++;
                    end
                end else begin
                    mh[i]++;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int   m;
            logic act, hin, vin;
            m   = mm[i];
            act = (m == 0);
            hin = (mh[i] >= hs0(m)) && (mh[i] <= hs1(m));
            vin = (mv[i] >= vs0(m)) && (mv[i] <= vs1(m));
            chk($sformatf("d%0d hcount", i), 32'(hc[i]), mh[i]);
            chk($sformatf("d%0d vcount", i), 32'(vc[i]), mv[i]);
            chk($sformatf("d%0d hblnk", i), 32'(hb[i]), 32'(mh[i] >= hbs(m)));
            chk($sformatf("d%0d vblnk", i), 32'(vb[i]), 32'(mv[i] >= vbs(m)));
            chk($sformatf("d%0d hsync", i), 32'(hs[i]), 32'(hin ? act : !act));
            chk($sformatf("d%0d vsync", i), 32'(vs[i]), 32'(vin ? act : !act));
            chk($sformatf("d%0d frame_start", i), 32'(fs[i]), mfs[i]);
            chk($sformatf("d%0d mode_act", i), 32'(ma[i]), m);
        end
    endtask

    // Called at a negedge: drive, clock, then check at the following negedge
    task automatic step(input logic en_v, input logic sel_v);
        en       = en_v;
        mode_sel = sel_v;
        @(posedge clk);
        model_step(en_v, sel_v);
        @(negedge clk);
        check_all();
    endtask

    // sel: 0/1 hold mode_sel fixed, 2 randomize every cycle
    task automatic run(input int n, input int sel);
        for (int k = 0; k < n; k++) begin
            logic e, s;
            e = ($urandom_range(0, 3) != 0);
            s = (sel == 2) ? logic'($urandom_range(0, 1)) : logic'(sel);
            step(e, s);
        end
    endtask

    // Preload both rasters by overriding the next-count nets for one enabled edge
    task automatic jump(input int h0, input int v0, input int h1, input int v1);
        if ((mh[0] == htot(mm[0]) - 1 && mv[0] == vtot(mm[0]) - 1) ||
            (mh[1] == htot(mm[1]) - 1 && mv[1] == vtot(mm[1]) - 1))
            step(1'b1, mode_sel);
        jh0 = CNT_W'(h0);
        jv0 = CNT_W'(v0);
        jh1 = CNT_W'(h1);
        jv1 = CNT_W'(v1);
        force dut0.hcount_d = jh0;
        force dut0.vcount_d = jv0;
        force dut1.hcount_d = jh1;
        force dut1.vcount_d = jv1;
        en = 1'b1;
        @(posedge clk);
        #1;
        release dut0.hcount_d;
        release dut0.vcount_d;
        release dut1.hcount_d;
        release dut1.vcount_d;
        en = 1'b0;
        mh[0] = h0; mv[0] = v0; mh[1] = h1; mv[1] = v1;
        mfs[0] = 0; mfs[1] = 0;
        @(negedge clk);
        check_all();
    endtask

    task automatic segment(input int kind, input int sel, input int n);
        int th [2];
        int tv [2];
        for (int i = 0; i < 2; i++) begin
            int m;
            m = mm[i];
            case (kind)
                0:       begin th[i] = hbs(m) - 10;  tv[i] = int'($urandom_range(1, vbs(m) - 1)); end
                1:       begin th[i] = htot(m) - 6;  tv[i] = vbs(m) - 1;  end
                2:       begin th[i] = htot(m) - 6;  tv[i] = vs0(m) - 1;  end
                3:       begin th[i] = htot(m) - 6;  tv[i] = vs1(m);      end
                default: begin th[i] = htot(m) - 6;  tv[i] = vtot(m) - 1; end
            endcase
        end
        jump(th[0], tv[0], th[1], tv[1]);
        run(n, sel);
    endtask

    // Reset dropped between edges must show reset values before the next edge
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        mode_sel = 1'b0;
        jh0 = '0; jv0 = '0; jh1 = '0; jv1 = '0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        run(40, 2);

        for (int s = 0; s < 12; s++)
            segment(seq_kind[s], seq_sel[s], 300);

        segment(0, 2, 50);
        async_reset();
        run(60, 2);
        segment(4, 2, 300);
        segment(4, 0, 300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
